// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO: any DEPTH >= 2, FWFT or standard read,
// almost flags, overflow/underflow pulses, synchronous flush.
module sync_fifo_v2 #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    data_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [WIDTH-1:0] r_ram [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_nonzero;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  logic [WIDTH-1:0] w_head;

  assign w_nonzero = (r_count != '0);
  assign w_full    = (r_count == FULLC);

  // A write into a full FIFO is legal only alongside an accepted read.
  assign w_rd_acc = rd_en & w_nonzero & ~flush;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc) & ~flush;

  assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
  assign w_head   = r_ram[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_ram[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_nxt;
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovf <= wr_en & ~w_wr_acc;
      r_unf <= rd_en & ~w_rd_acc;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign dout  = w_nonzero ? w_head : '0;
    assign valid = w_nonzero;
  end else begin : g_std
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else if (flush) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_acc;
        if (w_rd_acc) begin
          r_dout <= w_head;
        end
      end
    end

    assign dout  = r_dout;
    assign valid = r_valid;
  end

  assign full         = w_full;
  assign empty        = ~w_nonzero;
  assign almost_full  = (int'(r_count) >= AF_THRESH);
  assign almost_empty = (int'(r_count) <= AE_THRESH);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  assign data_count   = r_count;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: a DEPTH=5 FWFT instance and a DEPTH=16
// standard-read instance, each checked against a queue scoreboard.
module tb_sync_fifo_v2;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic       fl_a = 0, we_a = 0, re_a = 0;
  logic [7:0] din_a = 0, dout_a;
  logic       val_a, full_a, emp_a, af_a, ae_a, ovf_a, unf_a;
  logic [2:0] cnt_a;

  logic       fl_b = 0, we_b = 0, re_b = 0;
  logic [7:0] din_b = 0, dout_b;
  logic       val_b, full_b, emp_b, af_b, ae_b, ovf_b, unf_b;
  logic [4:0] cnt_b;

  sync_fifo_v2 #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_a (
    .clk(clk), .arst_n(arst_n), .flush(fl_a), .din(din_a),
    .wr_en(we_a), .rd_en(re_a), .dout(dout_a), .valid(val_a),
    .full(full_a), .empty(emp_a), .almost_full(af_a),
    .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a),
    .data_count(cnt_a)
  );

  sync_fifo_v2 #(.WIDTH(8), .DEPTH(16), .FWFT(0),
                 .AF_THRESH(6), .AE_THRESH(2)) u_b (
    .clk(clk), .arst_n(arst_n), .flush(fl_b), .din(din_b),
    .wr_en(we_b), .rd_en(re_b), .dout(dout_b), .valid(val_b),
    .full(full_b), .empty(emp_b), .almost_full(af_b),
    .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b),
    .data_count(cnt_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int ma = 0;
  int mb = 0;
  logic [7:0] lastb = 8'h00;

  task automatic cyc_a(input bit f, input bit w, input bit r,
                       input logic [7:0] d);
    bit ra, wa;
    logic [7:0] e, h;
    logic [6:0] xf, gf;
    fl_a = f; we_a = w; re_a = r; din_a = d;
    ra = !f && r && (ma != 0);
    wa = !f && w && ((ma != 5) || ra);
    if (ra) begin
      e = qa.pop_front();
      checks++;
      if (dout_a !== e) begin
        errors++;
        $display("FAIL a_pop got %h exp %h", dout_a, e);
      end
    end
    if (wa) qa.push_back(d);
    if (f) begin
      qa.delete();
      ma = 0;
    end else begin
      ma = ma + int'(wa) - int'(ra);
    end
    @(posedge clk); #1;
    fl_a = 0; we_a = 0; re_a = 0;
    h = (ma != 0) ? qa[0] : 8'h00;
    xf = {ma == 5, ma == 0, ma >= 3, ma <= 2,
          !f && w && !wa, !f && r && !ra, ma != 0};
    gf = {full_a, emp_a, af_a, ae_a, ovf_a, unf_a, val_a};
    checks++;
    if (gf !== xf) begin
      errors++;
      $display("FAIL a_flags got %b exp %b", gf, xf);
    end
    checks++;
    if (cnt_a !== 3'(ma)) begin
      errors++;
      $display("FAIL a_count got %0d exp %0d", cnt_a, ma);
    end
    checks++;
    if (dout_a !== h) begin
      errors++;
      $display("FAIL a_head got %h exp %h", dout_a, h);
    end
  endtask

  task automatic cyc_b(input bit w, input bit r, input logic [7:0] d);
    bit ra, wa;
    logic [7:0] e;
    logic [6:0] xf, gf;
    we_b = w; re_b = r; din_b = d;
    ra = r && (mb != 0);
    wa = w && ((mb != 16) || ra);
    e = ra ? qb.pop_front() : lastb;
    if (wa) qb.push_back(d);
    mb = mb + int'(wa) - int'(ra);
    @(posedge clk); #1;
    we_b = 0; re_b = 0;
    lastb = e;
    xf = {mb == 16, mb == 0, mb >= 6, mb <= 2, w && !wa, r && !ra, ra};
    gf = {full_b, emp_b, af_b, ae_b, ovf_b, unf_b, val_b};
    checks++;
    if (gf !== xf) begin
      errors++;
      $display("FAIL b_flags got %b exp %b", gf, xf);
    end
    checks++;
    if (cnt_b !== 5'(mb)) begin
      errors++;
      $display("FAIL b_count got %0d exp %0d", cnt_b, mb);
    end
    checks++;
    if (dout_b !== e) begin
      errors++;
      $display("FAIL b_dout got %h exp %h", dout_b, e);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    logic [15:0] g, x;
    g = {full_a, emp_a, af_a, ae_a, ovf_a, unf_a, val_a,
         full_b, emp_b, af_b, ae_b, ovf_b, unf_b, val_b, 2'b00};
    x = 16'b0101000_0101000_00;
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s_flags got %b exp %b", nm, g, x);
    end
    checks++;
    if ({dout_a, dout_b, cnt_a, cnt_b} !== 24'h0) begin
      errors++;
      $display("FAIL %s_data got %h %h %0d %0d exp 0", nm,
               dout_a, dout_b, cnt_a, cnt_b);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_vals("reset");
    #12 arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) cyc_a(0, 1, 0, 8'hA1 + 8'(i));
  endtask

  task automatic test_overflow_pass();
    cyc_a(0, 1, 0, 8'hB6);
    cyc_a(0, 1, 1, 8'hB6);
    for (int i = 0; i < 5; i++) cyc_a(0, 0, 1, 8'h00);
    cyc_a(0, 0, 1, 8'h00);
  endtask

  task automatic test_underflow();
    cyc_a(0, 1, 1, 8'h3C);
    cyc_a(0, 0, 1, 8'h00);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) cyc_a(0, 1, 0, 8'h50 + 8'(i));
    cyc_a(1, 1, 0, 8'hEE);
    cyc_a(0, 1, 0, 8'h77);
    cyc_a(0, 1, 0, 8'h78);
    cyc_a(0, 0, 1, 8'h00);
    cyc_a(0, 0, 1, 8'h00);
  endtask

  task automatic test_std_read();
    for (int i = 0; i < 7; i++) cyc_b(1, 0, 8'h10 + 8'(i));
    for (int i = 0; i < 7; i++) cyc_b(0, 1, 8'h00);
    cyc_b(0, 1, 8'h00);
    for (int i = 0; i < 13; i++) cyc_b(1, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 13; i++) cyc_b(0, 1, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) cyc_b(1, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) cyc_b(1, 1, 8'($urandom));
    for (int i = 0; i < 8; i++)
      cyc_b(1'($urandom), 1'($urandom), 8'($urandom));
    for (int i = 0; i < 12; i++)
      cyc_a(0, 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic test_async_reset();
    we_a = 1; din_a = 8'hC1; we_b = 1; din_b = 8'hC2;
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    check_reset_vals("areset");
    we_a = 0; we_b = 0;
    qa.delete(); qb.delete();
    ma = 0; mb = 0; lastb = 8'h00;
    #2 arst_n = 1'b1;
    @(posedge clk); #1;
    cyc_a(0, 1, 0, 8'h9A);
    cyc_b(1, 0, 8'h9B);
    cyc_a(0, 0, 1, 8'h00);
    cyc_b(0, 1, 8'h00);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_pass();
    test_underflow();
    test_flush();
    test_std_read();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
